// File: rtl/transpose_pkg.sv
// Shared constants, register map and FSM encoding for the in-place matrix transpose peripheral.
// Widths are derived from the matrix dimension so one package serves every N_MAX.
package transpose_pkg;

    localparam int unsigned N_MAX_DEFAULT = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n * n);
    endfunction

    function automatic int unsigned dim_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned IDX_W = idx_width(N_MAX_DEFAULT);
    localparam int unsigned DIM_W = dim_width(N_MAX_DEFAULT);

    // Word index within the window (byte offset / 2)
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_DIM    = 3'd2;
    localparam logic [2:0] REG_IDX    = 3'd3;
    localparam logic [2:0] REG_DATA   = 3'd4;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_MODE  = 1;
    localparam int unsigned CTRL_IE    = 2;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_ERR  = 2;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

endpackage

// File: rtl/transpose_addr_gen.sv
// Walks the upper (transpose) or upper-left (anti-transpose) triangle one pair per step and
// emits the two row-major element indices to swap, plus a flag on the final pair.
module transpose_addr_gen
    import transpose_pkg::*;
#(
    parameter int unsigned DW = DIM_W,
    parameter int unsigned IW = IDX_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic          mode,
    input  logic [DW-1:0] dim,
    output logic [IW-1:0] idx_a,
    output logic [IW-1:0] idx_b,
    output logic          last
);

    // i is the row; k counts positions within that row's share of the triangle
    logic [DW-1:0] i_q, i_d, k_q, k_d;
    logic [DW-1:0] k_max, dim_m1;
    logic [DW-1:0] col_a, row_b, col_b;

    assign dim_m1 = dim - DW'(1);
    assign k_max  = dim - DW'(2) - i_q;
    assign last   = (i_q == dim - DW'(2));

    always_comb begin
        col_a = '0;
        row_b = '0;
        col_b = '0;
        if (mode) begin
            col_a = k_q;
            row_b = dim_m1 - k_q;
            col_b = dim_m1 - i_q;
        end else begin
            col_a = i_q + DW'(1) + k_q;
            row_b = col_a;
            col_b = i_q;
        end
    end

    assign idx_a = IW'(i_q) * IW'(dim) + IW'(col_a);
    assign idx_b = IW'(row_b) * IW'(dim) + IW'(col_b);

    always_comb begin
        i_d = i_q;
        k_d = k_q;
        if (load) begin
            i_d = '0;
            k_d = '0;
        end else if (step) begin
            if (k_q == k_max) begin
                i_d = i_q + DW'(1);
                k_d = '0;
            end else begin
                k_d = k_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/transpose_engine.sv
// openMSP430 peripheral holding a DIM x DIM matrix of 16-bit words; transposes or
// anti-transposes it in place, one swap per cycle, with a level completion interrupt.
module transpose_engine
    import transpose_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0190,
    parameter int unsigned N_MAX     = N_MAX_DEFAULT
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        irq,
    input  logic        irq_acc
);

    localparam int unsigned IW    = idx_width(N_MAX);
    localparam int unsigned IW1   = IW + 1;
    localparam int unsigned DW    = dim_width(N_MAX);
    localparam int unsigned DEPTH = N_MAX * N_MAX;
    localparam logic [DW-1:0] DIM_MAX = DW'(N_MAX);

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic          ie_q, ie_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [DW-1:0] dim_q, dim_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [15:0] mem [DEPTH];

    logic          sel, rd_en, wr_en, busy;
    logic [2:0]    reg_sel;
    logic          wr_ctrl, wr_status, wr_dim, wr_idx, wr_data, data_acc;
    logic          start_req, go, done_set, done_clr;
    logic [IW:0]   dim_sq, idx_p1;
    logic [IW-1:0] idx_inc;
    logic [DW-1:0] dim_wr_val;
    logic [IW-1:0] ag_a, ag_b;
    logic          ag_last;

    assign sel     = per_en & (per_addr[13:3] == BASE_ADDR[14:4]);
    assign reg_sel = per_addr[2:0];
    assign rd_en   = sel & (per_we == 2'b00);
    assign wr_en   = sel & (per_we == 2'b11);
    assign busy    = (state_q == StRun);

    assign wr_ctrl   = wr_en & (reg_sel == REG_CTRL);
    assign wr_status = wr_en & (reg_sel == REG_STATUS);
    assign wr_dim    = wr_en & (reg_sel == REG_DIM);
    assign wr_idx    = wr_en & (reg_sel == REG_IDX);
    assign wr_data   = wr_en & (reg_sel == REG_DATA);
    assign data_acc  = (rd_en | wr_en) & (reg_sel == REG_DATA);

    assign start_req = wr_ctrl & per_din[CTRL_START] & ~busy;
    assign go        = start_req & (dim_q > DW'(1));
    // A 1x1 matrix is already its own transpose: finish without entering RUN
    assign done_set  = (start_req & (dim_q == DW'(1))) | (busy & ag_last);
    assign done_clr  = irq_acc | (wr_status & per_din[STAT_DONE]) | go;

    assign dim_sq  = IW1'(dim_q) * IW1'(dim_q);
    assign idx_p1  = IW1'(idx_q) + IW1'(1);
    assign idx_inc = (idx_p1 >= dim_sq) ? '0 : idx_p1[IW-1:0];

    always_comb begin
        dim_wr_val = DW'(per_din);
        if (per_din == 16'd0) begin
            dim_wr_val = DW'(1);
        end else if (per_din > 16'(N_MAX)) begin
            dim_wr_val = DIM_MAX;
        end
    end

    transpose_addr_gen #(
        .DW(DW),
        .IW(IW)
    ) u_addr_gen (
        .clk  (mclk),
        .rst_n(reset_n),
        .load (go),
        .step (busy),
        .mode (mode_q),
        .dim  (dim_q),
        .idx_a(ag_a),
        .idx_b(ag_b),
        .last (ag_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (go) state_d = StRun;
            StRun:  if (ag_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        ie_d   = ie_q;
        done_d = done_q;
        err_d  = err_q;
        dim_d  = dim_q;
        idx_d  = idx_q;
        // MODE is frozen while running so the iterator sees a stable pattern
        if (wr_ctrl) begin
            ie_d = per_din[CTRL_IE];
            if (!busy) mode_d = per_din[CTRL_MODE];
        end
        if (!busy) begin
            if (wr_dim) dim_d = dim_wr_val;
            if (wr_idx) idx_d = (per_din >= 16'(dim_sq)) ? '0 : IW'(per_din);
            if (data_acc) idx_d = idx_inc;
        end
        if (busy & (wr_dim | wr_idx | wr_data)) begin
            err_d = 1'b1;
        end else if (wr_status & per_din[STAT_ERR]) begin
            err_d = 1'b0;
        end
        if (done_set) begin
            done_d = 1'b1;
        end else if (done_clr) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            ie_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dim_q   <= DIM_MAX;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dim_q   <= dim_d;
            idx_q   <= idx_d;
        end
    end

    // Matrix storage is deliberately unreset
    always_ff @(posedge mclk) begin
        if (busy) begin
            mem[ag_a] <= mem[ag_b];
            mem[ag_b] <= mem[ag_a];
        end else if (wr_data) begin
            mem[idx_q] <= per_din;
        end
    end

    assign irq = done_q & ie_q;

    always_comb begin
        per_dout = '0;
        if (rd_en) begin
            case (reg_sel)
                REG_CTRL: begin
                    per_dout[CTRL_MODE] = mode_q;
                    per_dout[CTRL_IE]   = ie_q;
                end
                REG_STATUS: begin
                    per_dout[STAT_BUSY] = busy;
                    per_dout[STAT_DONE] = done_q;
                    per_dout[STAT_ERR]  = err_q;
                end
                REG_DIM:  per_dout = 16'(dim_q);
                REG_IDX:  per_dout = 16'(idx_q);
                REG_DATA: if (!busy) per_dout = mem[idx_q];
                default:  per_dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_transpose_engine.sv
// Bench for transpose_engine: a transaction-level model of the register file and matrix
// predicts every read and irq each cycle; directed literals pin the model's arithmetic.
module tb_transpose_engine;

    localparam logic [14:0] BASE = 15'h0190;
    localparam int NM = 8;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic        irq;
    logic        irq_acc;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Model state
    int          m_dim, m_idx, m_busy;
    bit          m_mode, m_ie, m_done, m_err;
    logic [15:0] m_mem [256];
    bit          m_val [256];
    logic [15:0] m_pend [256];
    bit          m_pval [256];

    transpose_engine #(
        .BASE_ADDR(BASE),
        .N_MAX    (NM)
    ) dut (
        .mclk    (mclk),
        .reset_n (reset_n),
        .per_addr(per_addr),
        .per_din (per_din),
        .per_en  (per_en),
        .per_we  (per_we),
        .per_dout(per_dout),
        .irq     (irq),
        .irq_acc (irq_acc)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: applies one bus cycle per clock edge
    always @(posedge mclk or negedge reset_n) begin : model
        bit was_busy, dset, rd, wr;
        int src, sq;
        if (!reset_n) begin
            m_dim = NM; m_idx = 0; m_busy = 0;
            m_mode = 0; m_ie = 0; m_done = 0; m_err = 0;
            for (int n = 0; n < 256; n++) m_val[n] = 0;
        end else begin
            was_busy = (m_busy > 0);
            dset = 0;
            rd = per_en && (per_addr[13:3] == BASE[14:4]) && (per_we == 2'b00);
            wr = per_en && (per_addr[13:3] == BASE[14:4]) && (per_we == 2'b11);
            sq = m_dim * m_dim;
            if (was_busy) begin
                m_busy--;
                if (m_busy == 0) begin
                    for (int n = 0; n < 256; n++) begin
                        m_mem[n] = m_pend[n];
                        m_val[n] = m_pval[n];
                    end
                    dset = 1;
                end
            end
            if (wr) begin
                case (per_addr[2:0])
                    3'd0: begin
                        m_ie = per_din[2];
                        if (!was_busy) begin
                            m_mode = per_din[1];
                            if (per_din[0]) begin
                                if (m_dim > 1) begin
                                    for (int n = 0; n < 256; n++) begin
                                        m_pend[n] = m_mem[n];
                                        m_pval[n] = m_val[n];
                                    end
                                    for (int r = 0; r < m_dim; r++)
                                        for (int c = 0; c < m_dim; c++) begin
                                            src = per_din[1] ? (m_dim-1-c)*m_dim + (m_dim-1-r)
                                                             : c*m_dim + r;
                                            m_pend[r*m_dim+c] = m_mem[src];
                                            m_pval[r*m_dim+c] = m_val[src];
                                        end
                                    m_busy = m_dim * (m_dim - 1) / 2;
                                    m_done = 0;
                                end else begin
                                    dset = 1;
                                end
                            end
                        end
                    end
                    3'd1: begin
                        if (per_din[1]) m_done = 0;
                        if (per_din[2]) m_err = 0;
                    end
                    3'd2: if (was_busy) m_err = 1;
                          else m_dim = (per_din == 0) ? 1 : (int'(per_din) > NM) ? NM
                                                         : int'(per_din);
                    3'd3: if (was_busy) m_err = 1;
                          else m_idx = (int'(per_din) >= sq) ? 0 : int'(per_din);
                    3'd4: if (was_busy) m_err = 1;
                          else begin
                              m_mem[m_idx] = per_din;
                              m_val[m_idx] = 1;
                              m_idx = (m_idx + 1) % sq;
                          end
                    default: ;
                endcase
            end
            if (rd && per_addr[2:0] == 3'd4 && !was_busy) m_idx = (m_idx + 1) % sq;
            if (irq_acc) m_done = 0;
            if (dset) m_done = 1;
        end
    end

    function automatic void model_dout(output logic [15:0] e, output bit known);
        e = '0;
        known = 1;
        if (per_en && per_addr[13:3] == BASE[14:4] && per_we == 2'b00) begin
            case (per_addr[2:0])
                3'd0: e = {13'd0, m_ie, m_mode, 1'b0};
                3'd1: e = {13'd0, m_err, m_done, (m_busy > 0)};
                3'd2: e = 16'(m_dim);
                3'd3: e = 16'(m_idx);
                3'd4: if (m_busy == 0) begin
                          if (m_val[m_idx]) e = m_mem[m_idx];
                          else known = 0;
                      end
                default: e = '0;
            endcase
        end
    endfunction

    // Per-cycle comparison of every observable output against the model
    always @(negedge mclk) begin : compare
        logic [15:0] e;
        bit known;
        if (chk_en && reset_n) begin
            model_dout(e, known);
            if (known) chk("per_dout", per_dout, e);
            chk("irq", irq, m_done & m_ie);
        end
    end

    task automatic idle_bus();
        per_en = 0; per_we = 2'b00; per_addr = '0; per_din = '0;
    endtask

    task automatic bus(input logic [2:0] r, input logic [1:0] we, input logic [15:0] d,
                       output logic [15:0] v);
        per_en = 1; per_we = we; per_addr = {BASE[14:4], r}; per_din = d;
        @(negedge mclk);
        v = per_dout;
        @(posedge mclk);
        #1;
        idle_bus();
    endtask

    task automatic wr(input logic [2:0] r, input logic [15:0] d);
        logic [15:0] v;
        bus(r, 2'b11, d, v);
    endtask

    task automatic rd(input logic [2:0] r, output logic [15:0] v);
        bus(r, 2'b00, 16'h0, v);
    endtask

    task automatic idle_cycle();
        @(posedge mclk);
        #1;
    endtask

    task automatic poll_busy(output int n, output logic [15:0] last_v);
        bit ok = 0;
        n = 0;
        last_v = '0;
        for (int g = 0; g < 300; g++) begin
            rd(3'd1, last_v);
            if (!last_v[0]) begin
                ok = 1;
                break;
            end
            n++;
        end
        if (!ok) chk("busy_timeout", 1, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] v;
        int n, d;
        int exp4[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
        int exp3[9]  = '{8, 5, 2, 7, 4, 1, 6, 3, 0};

        reset_n = 0;
        irq_acc = 0;
        idle_bus();
        repeat (3) @(posedge mclk);
        #1;
        reset_n = 1;
        chk_en = 1;

        // Reset values
        rd(3'd0, v); chk("rst_ctrl", v, 0);
        rd(3'd1, v); chk("rst_status", v, 0);
        rd(3'd2, v); chk("rst_dim", v, 8);
        rd(3'd3, v); chk("rst_idx", v, 0);
        chk("rst_irq", irq, 0);
        per_en = 1; per_we = 2'b00; per_addr = {11'h1A, 3'd2};
        @(negedge mclk);
        chk("unsel_dout", per_dout, 0);
        @(posedge mclk); #1; idle_bus();
        rd(3'd5, v); chk("reserved_reg", v, 0);

        // DIM=4 transpose
        wr(3'd2, 16'd4);
        bus(3'd2, 2'b01, 16'd3, v);  // byte write ignored
        rd(3'd2, v); chk("byte_wr_ignored", v, 4);
        wr(3'd3, 16'd0);
        for (int k = 0; k < 16; k++) wr(3'd4, 16'(k));
        rd(3'd3, v); chk("idx_wrap_wr", v, 0);
        wr(3'd0, 16'h0001);
        poll_busy(n, v);
        chk("busy4_cycles", n, 6);
        chk("done4_status", v, 3'b010);
        for (int k = 0; k < 16; k++) begin
            rd(3'd4, v);
            chk("t4_data", v, exp4[k]);
        end
        rd(3'd3, v); chk("idx_wrap_rd", v, 0);

        // DIM=3 anti-transpose
        wr(3'd2, 16'd3);
        wr(3'd3, 16'd0);
        for (int k = 0; k < 9; k++) wr(3'd4, 16'(k));
        wr(3'd0, 16'h0003);
        poll_busy(n, v);
        chk("busy3_cycles", n, 3);
        for (int k = 0; k < 9; k++) begin
            rd(3'd4, v);
            chk("a3_data", v, exp3[k]);
        end

        // DIM=1 and DIM saturation
        wr(3'd2, 16'd1);
        wr(3'd3, 16'd0);
        wr(3'd4, 16'h1234);
        wr(3'd1, 16'h0006);
        rd(3'd1, v); chk("w1c_done", v, 0);
        wr(3'd0, 16'h0001);
        rd(3'd1, v); chk("dim1_status", v, 3'b010);
        rd(3'd4, v); chk("dim1_elem", v, 16'h1234);
        wr(3'd2, 16'd0);
        rd(3'd2, v); chk("dim_sat0", v, 1);
        wr(3'd2, 16'd20);
        rd(3'd2, v); chk("dim_sat20", v, 8);

        // DIM=8 run with illegal accesses while busy
        wr(3'd3, 16'd0);
        for (int k = 0; k < 64; k++) wr(3'd4, 16'($urandom));
        wr(3'd3, 16'd5);
        wr(3'd0, 16'h0001);
        wr(3'd4, 16'hDEAD);
        wr(3'd3, 16'd9);
        wr(3'd0, 16'h0001);
        wr(3'd2, 16'd3);
        rd(3'd4, v); chk("busy_data_rd", v, 0);
        rd(3'd1, v); chk("busy_err_status", v, 3'b101);
        rd(3'd3, v); chk("busy_idx_held", v, 5);
        poll_busy(n, v);
        chk("busy8_cycles", n + 7, 28);
        chk("done8_status", v, 3'b110);
        wr(3'd1, 16'h0004);
        rd(3'd1, v); chk("w1c_err", v, 3'b010);
        rd(3'd2, v); chk("dim_held", v, 8);
        wr(3'd3, 16'd0);
        for (int k = 0; k < 64; k++) rd(3'd4, v);

        // Interrupt behaviour on a 2x2 (single-swap) run
        wr(3'd2, 16'd2);
        wr(3'd1, 16'h0006);
        wr(3'd0, 16'h0005);
        chk("irq_low_busy", irq, 0);
        idle_cycle();
        chk("irq_rise", irq, 1);
        irq_acc = 1;
        idle_cycle();
        irq_acc = 0;
        chk("irq_acc_clear", irq, 0);
        wr(3'd0, 16'h0005);
        irq_acc = 1;
        idle_cycle();
        irq_acc = 0;
        chk("irq_acc_vs_set", irq, 1);
        wr(3'd0, 16'h0005);
        wr(3'd1, 16'h0002);
        rd(3'd1, v); chk("w1c_vs_set", v, 3'b010);
        wr(3'd0, 16'h0000);
        chk("irq_ie_off", irq, 0);

        // Randomised runs, checked by the model
        for (int t = 0; t < 6; t++) begin
            d = $urandom_range(2, 8);
            wr(3'd2, 16'(d));
            wr(3'd3, 16'd0);
            for (int k = 0; k < d * d; k++) wr(3'd4, 16'($urandom));
            wr(3'd0, {13'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
            poll_busy(n, v);
            chk("rand_busy_cycles", n, d * (d - 1) / 2);
            wr(3'd3, 16'($urandom_range(0, 80)));
            rd(3'd3, v);
            wr(3'd3, 16'd0);
            for (int k = 0; k < d * d; k++) rd(3'd4, v);
        end

        // Asynchronous reset in the middle of a run
        wr(3'd2, 16'd8);
        wr(3'd0, 16'h0001);
        wr(3'd4, 16'h0BAD);
        idle_cycle();
        per_en = 1; per_we = 2'b00; per_addr = {BASE[14:4], 3'd1};
        #1;
        chk("pre_reset_status", per_dout, 3'b101);
        reset_n = 0;
        #1;
        chk("async_reset_status", per_dout, 0);
        chk("async_reset_irq", irq, 0);
        @(posedge mclk);
        #1;
        idle_bus();
        reset_n = 1;
        rd(3'd1, v); chk("post_reset_status", v, 0);
        rd(3'd2, v); chk("post_reset_dim", v, 8);
        repeat (3) idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/transpose_engine.md
Name: transpose_engine

Overview:
- Memory-mapped openMSP430 peripheral that holds a square matrix of up to N_MAX x N_MAX 16-bit words and transposes it in place in hardware.
- Parametrised successor to the fixed transpose support peripheral:
  - runtime dimension 1..N_MAX;
  - two modes: transpose and anti-transpose;
  - auto-incrementing data window;
  - completion interrupt.
- Sits on the per_* bus beside gpio, timerA and uart; its per_dout is ORed into the CPU per_dout.

Parameters:
- BASE_ADDR, 15'h0190, byte base address of the 16-byte register window; must be 16-byte aligned.
- N_MAX, 8, maximum matrix dimension (2..16); storage is N_MAX*N_MAX words.

Ports:
- mclk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- per_addr  in  14  peripheral word address
- per_din  in  16  peripheral write data
- per_en  in  1  peripheral access enable
- per_we  in  2  byte write enables; 2'b00 = read
- per_dout  out  16  read data; 0 when not selected or on a write
- irq  out  1  completion interrupt, level
- irq_acc  in  1  interrupt accepted pulse from CPU

Behaviour:
- Clock and reset: one clock, mclk. Reset is reset_n, asynchronous and active-low. All state registers reset as listed below. Matrix storage is not reset; its contents are undefined after reset.
- Select: sel = per_en & (per_addr[13:3] == BASE_ADDR[14:4]). Register index = per_addr[2:0].
- Writes take effect only when per_we == 2'b11; byte writes are ignored.
- per_dout is combinational in the access cycle.
- Register map (byte offsets):
  - 0x0 CTRL: bit0 START (write 1 to start; reads 0), bit1 MODE (0 transpose, 1 anti-transpose), bit2 IE. Reset 0.
  - 0x2 STATUS: bit0 BUSY (read-only), bit1 DONE (write-1-to-clear), bit2 ERR (write-1-to-clear). Reset 0.
  - 0x4 DIM: reset N_MAX. A write of 0 saturates to 1; a write above N_MAX saturates to N_MAX.
  - 0x6 IDX: linear element index, reset 0. A write of a value >= DIM*DIM loads 0.
  - 0x8 DATA: reads/writes element[IDX], row-major with stride DIM. IDX increments after each DATA access and wraps from DIM*DIM-1 to 0.
  - 0xA-0xE: read 0.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on a START write when DIM > 1. MODE and IE are taken from that same write. DONE is cleared. The iterator is loaded to i=0, j=0.
  - START with DIM = 1 leaves the FSM in IDLE and sets DONE on that edge; BUSY never asserts.
  - RUN performs exactly one swap per cycle.
    - Mode 0: swap (i,j) with (j,i) for all i<j.
    - Mode 1: swap (i,j) with (DIM-1-j, DIM-1-i) for all i+j < DIM-1.
  - Both modes perform S = DIM*(DIM-1)/2 swaps. BUSY is high for exactly S cycles, starting the cycle after the START write.
  - On the last swap edge: RUN -> IDLE, BUSY=0, DONE=1.
- During BUSY:
  - DATA reads return 0.
  - DATA writes, DIM writes and IDX writes are ignored and set ERR.
  - IDX does not advance.
  - START is ignored.
- irq = DONE & IE.
- irq_acc clears DONE. If irq_acc and a DONE set occur in the same cycle, the set wins. The same priority applies to a W1C of DONE coinciding with the set.
- If reset_n asserts mid-run, BUSY, DONE and ERR go to 0 immediately; matrix contents are undefined.

Decomposition:
- Package transpose_pkg:
  - register offsets and bit positions;
  - FSM state enum;
  - width constants IDX_W = clog2(N_MAX*N_MAX) and DIM_W = clog2(N_MAX+1).
- Sub-module transpose_addr_gen:
  - (i,j) iterator for both modes;
  - produces the two linear indices (row*DIM+col) and a last flag.

Test Plan:
- Reset -> CTRL=0, STATUS=0, DIM=8, IDX=0, irq=0, per_dout=0 for unselected addresses.
- DIM=4; write 0..15 through DATA; START mode0 -> BUSY exactly 6 cycles, then DONE=1. Readback from IDX=0 gives 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15, and IDX wraps to 0.
- DIM=3, values 0..8, START mode1 -> BUSY 3 cycles; readback 8,5,2,7,4,1,6,3,0.
- DIM=1, START -> DONE set on the next edge, BUSY never high, element 0 unchanged. DIM writes of 0 and 20 read back 1 and 8.
- During a DIM=8 run (28 cycles): DATA write, IDX write, and START all ignored; ERR=1; IDX unchanged. W1C on ERR clears it.
- IE=1 -> irq rises with DONE; an irq_acc pulse drops it. irq_acc coincident with the DONE set leaves DONE=1. reset_n low mid-run clears BUSY and DONE asynchronously.
